pp_pipeline_accel_fifo_to_axis: RTL

//  Drain stage directly downstream of the pre-processing pipeline's 11-bit ap_fifo-style channel.

---
 rtl/pp_pipeline_accel_fifo_to_axis.sv | 207 ++++++++++++++++++++
 1 files changed

// File: rtl/pp_pipeline_accel_fifo_to_axis.sv
// Drains an ap_fifo-style word channel into one rows x cols AXI4-Stream frame (TUSER = SOF, TLAST = EOL).
// Optional statistics counters are enabled with `define PP_FIFO_TO_AXIS_STATS_EN.
module pp_pipeline_accel_fifo_to_axis #(
  parameter int DATA_WIDTH = 11,
  parameter int AXIS_WIDTH = 16,
  parameter int DIM_WIDTH  = 11
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [DIM_WIDTH-1:0]  rows,
  input  logic [DIM_WIDTH-1:0]  cols,
  output logic                  busy,
  output logic                  done,
  input  logic                  if_empty_n,
  output logic                  if_read,
  input  logic [DATA_WIDTH-1:0] if_dout,
  output logic [AXIS_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  output logic                  m_axis_tuser
`ifdef PP_FIFO_TO_AXIS_STATS_EN
  ,
  input  logic                  stats_clr,
  output logic [15:0]           frame_cnt,
  output logic [31:0]           stall_cnt
`endif
);

  localparam int PROD_W  = 2 * DIM_WIDTH;
  localparam int ENTRY_W = DATA_WIDTH + 2;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_FLUSH,
    ST_DONE
  } state_t;

  state_t state_q, state_d;

  logic [DIM_WIDTH-1:0] cols_q, cols_d;
  logic [DIM_WIDTH-1:0] col_cnt_q, col_cnt_d;
  logic [DIM_WIDTH-1:0] row_cnt_q, row_cnt_d;
  logic [PROD_W-1:0]    total_q, total_d;
  logic [PROD_W-1:0]    popped_q, popped_d;

  // Skid entry layout: {tuser, tlast, data}; slot 0 is always the head presented on the bus.
  logic [1:0][ENTRY_W-1:0] slot_q, slot_d;
  logic [1:0]              occ_q, occ_d;

  logic                  start_ok;
  logic                  zero_dim;
  logic                  pop;
  logic                  drain;
  logic                  pop_last;
  logic                  pop_tuser;
  logic                  last_pop;
  logic [1:0]            wr_idx;
  logic [ENTRY_W-1:0]    pop_entry;

  assign start_ok  = start && (state_q == ST_IDLE);
  assign zero_dim  = (rows == '0) || (cols == '0);

  assign m_axis_tvalid = (occ_q != 2'd0);
  assign drain         = m_axis_tvalid && m_axis_tready;

  // A full skid blocks the pop even if the head drains this cycle.
  assign pop = (state_q == ST_RUN) && if_empty_n && (occ_q != 2'd2) && (popped_q < total_q);
  assign if_read = pop;

  assign pop_last  = (col_cnt_q == (cols_q - DIM_WIDTH'(1)));
  assign pop_tuser = (row_cnt_q == '0) && (col_cnt_q == '0);
  assign pop_entry = {pop_tuser, pop_last, if_dout};
  assign last_pop  = pop && (popped_q == (total_q - PROD_W'(1)));

  assign m_axis_tdata = AXIS_WIDTH'(slot_q[0][DATA_WIDTH-1:0]);
  assign m_axis_tlast = slot_q[0][DATA_WIDTH];
  assign m_axis_tuser = slot_q[0][DATA_WIDTH+1];

  always_comb begin
    slot_d = slot_q;
    wr_idx = occ_q - {1'b0, drain};
    if (drain) begin
      slot_d[0] = slot_q[1];
    end
    if (pop) begin
      slot_d[wr_idx[0]] = pop_entry;
    end
    occ_d = occ_q + {1'b0, pop} - {1'b0, drain};
  end

  always_comb begin
    cols_d    = cols_q;
    total_d   = total_q;
    popped_d  = popped_q;
    col_cnt_d = col_cnt_q;
    row_cnt_d = row_cnt_q;
    if (start_ok) begin
      cols_d    = cols;
      total_d   = PROD_W'(rows) * PROD_W'(cols);
      popped_d  = '0;
      col_cnt_d = '0;
      row_cnt_d = '0;
    end else if (pop) begin
      popped_d = popped_q + PROD_W'(1);
      if (pop_last) begin
        col_cnt_d = '0;
        row_cnt_d = row_cnt_q + DIM_WIDTH'(1);
      end else begin
        col_cnt_d = col_cnt_q + DIM_WIDTH'(1);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    busy    = 1'b0;
    done    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_ok) begin
          state_d = zero_dim ? ST_DONE : ST_RUN;
        end
      end
      ST_RUN: begin
        busy = 1'b1;
        if (last_pop) begin
          state_d = ST_FLUSH;
        end
      end
      ST_FLUSH: begin
        busy = 1'b1;
        // Leave as soon as the final beat is accepted so done lands one cycle later.
        if (occ_d == 2'd0) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      cols_q    <= '0;
      total_q   <= '0;
      popped_q  <= '0;
      col_cnt_q <= '0;
      row_cnt_q <= '0;
      slot_q    <= '0;
      occ_q     <= '0;
    end else begin
      state_q   <= state_d;
      cols_q    <= cols_d;
      total_q   <= total_d;
      popped_q  <= popped_d;
      col_cnt_q <= col_cnt_d;
      row_cnt_q <= row_cnt_d;
      slot_q    <= slot_d;
      occ_q     <= occ_d;
    end
  end

`ifdef PP_FIFO_TO_AXIS_STATS_EN
  logic [15:0] frame_cnt_q, frame_cnt_d;
  logic [31:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    frame_cnt_d = frame_cnt_q;
    stall_cnt_d = stall_cnt_q;
    if (stats_clr) begin
      frame_cnt_d = '0;
      stall_cnt_d = '0;
    end else begin
      if (done) begin
        frame_cnt_d = frame_cnt_q + 16'd1;
      end
      // Stall counter saturates instead of wrapping.
      if (m_axis_tvalid && !m_axis_tready && (stall_cnt_q != 32'hFFFF_FFFF)) begin
        stall_cnt_d = stall_cnt_q + 32'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      frame_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      frame_cnt_q <= frame_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign frame_cnt = frame_cnt_q;
  assign stall_cnt = stall_cnt_q;
`else
  // Statistics disabled: no counters or extra ports.
`endif

endmodule
